// File: rtl/part3_pkg.sv
// Shared definitions for the part3 Gray encoder / decoder pair.
package part3_pkg;

    localparam int GRAY_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/part3_gray_decoder.sv
// Sequential Gray-to-binary decoder: accepts one Gray word, rebuilds the binary
// value MSB-first at one bit per clock, then offers it on a valid/ready port.
module part3_gray_decoder
    import part3_pkg::*;
#(
    parameter int WIDTH = GRAY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] g_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y_out,
    output logic             busy,
    output state_t           state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; a source holds valid (and its data) stable until that edge.
    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

    state_t           state, state_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic [WIDTH-1:0] g_reg, g_next;
    logic [WIDTH-1:0] y_reg, y_next;
    logic [WIDTH-1:0] y_shift;

    // Bit above the one being written; the zero fill makes the MSB step g_reg[MSB].
    assign y_shift = {1'b0, y_reg[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= '0;
            g_reg <= '0;
            y_reg <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            g_reg <= g_next;
            y_reg <= y_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        g_next     = g_reg;
        y_next     = y_reg;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    g_next     = g_in;
                    y_next     = '0;
                    idx_next   = IDX_TOP;
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                y_next[idx] = y_shift[idx] ^ g_reg[idx];
                if (idx == '0) begin
                    state_next = ST_DONE;
                end else begin
                    idx_next = idx - 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state == ST_DECODE) || (state == ST_DONE);
    assign y_out     = y_reg;
    assign state_dbg = state;

endmodule

// File: tb/tb_part3_gray_decoder.sv
// Bench for part3_gray_decoder: cycle-level reference model, per-cycle compare,
// directed literal decodes, backpressure, mid-word reset and a loopback sweep.
module tb_part3_gray_decoder;
    import part3_pkg::*;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] g_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y_out;
    logic         busy;
    state_t       state_dbg;

    always #5 clk = ~clk;

    part3_gray_decoder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .g_in      (g_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_out     (y_out),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // ---------------- reference model ----------------
    // Inverse of the encoder found by search: the binary b with b ^ (b >> 1) == g.
    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] bv;
        for (int b = 0; b < (1 << W); b++) begin
            bv = W'(b);
            if ((bv ^ (bv >> 1)) == g) return bv;
        end
        return '0;
    endfunction

    bit           m_idle = 1'b1;
    bit           m_done = 1'b0;
    int           m_left = 0;
    logic [W-1:0] m_exp  = '0;
    int           cyc = 0;
    int           last_acc = 0;
    int           gap = 0;
    int           acc_cnt = 0;

    // Accept -> WIDTH decode edges -> result held until taken.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_idle = 1'b1;
            m_done = 1'b0;
            m_left = 0;
        end else begin
            cyc++;
            if (m_idle) begin
                if (in_valid === 1'b1) begin
                    m_idle   = 1'b0;
                    m_left   = W;
                    m_exp    = gray2bin(g_in);
                    gap      = cyc - last_acc;
                    last_acc = cyc;
                    acc_cnt++;
                end
            end else if (!m_done) begin
                m_left--;
                if (m_left == 0) m_done = 1'b1;
            end else if (out_ready === 1'b1) begin
                m_done = 1'b0;
                m_idle = 1'b1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int           total = 0;
    int           bad = 0;
    logic [W-1:0] exp_q[$];
    int           lit_req = 0;
    int           lit_done = 0;
    int           to_req = 0;
    int           to_seen = 0;
    int           acc_seen = 0;
    int           lb_next = 0;
    bit           sweep = 1'b0;
    int           sweep_base = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (rst === 1'b1) begin
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_y_out", 32'(y_out), 32'd0);
        end else begin
            chk("in_ready", 32'(in_ready), 32'(m_idle));
            chk("busy", 32'(busy), 32'(!m_idle));
            chk("out_valid", 32'(out_valid), 32'(m_done));
            if (m_done) chk("y_out", 32'(y_out), 32'(m_exp));
            if (lit_req != lit_done && out_valid === 1'b1) begin
                chk("lit_value", 32'(y_out), 32'(exp_q.pop_front()));
                chk("lit_latency", 32'(cyc - last_acc), 32'(W));
                lit_done++;
            end
            if (sweep && acc_cnt != acc_seen && acc_cnt > sweep_base + 1)
                chk("sweep_gap", 32'(gap), 32'(W + 2));
            if (sweep && out_valid === 1'b1 && out_ready === 1'b1) begin
                chk("loopback", 32'(y_out), 32'(lb_next[W-1:0]));
                lb_next++;
            end
        end
        acc_seen = acc_cnt;
        if (to_req != to_seen) begin
            chk("timeout", 32'(to_req), 32'(to_seen));
            to_seen = to_req;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_accept(output bit ok);
        int a0;
        a0 = acc_cnt;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk);
            #1;
            if (acc_cnt != a0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) to_req++;
    endtask

    task automatic decode_lit(input logic [W-1:0] g, input logic [W-1:0] lit);
        bit ok;
        @(negedge clk);
        #1;
        out_ready = 1'b1;
        g_in      = g;
        in_valid  = 1'b1;
        exp_q.push_back(lit);
        lit_req++;
        wait_accept(ok);
        in_valid = 1'b0;
        g_in     = W'($urandom);
        ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            #2;
            if (lit_done == lit_req) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) to_req++;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit           ok;
        logic [W-1:0] vb;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        g_in      = '0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;

        // Directed decodes with hand-computed results.
        decode_lit(8'b10101010, 8'b11001100);
        decode_lit(8'b11001100, 8'b10001000);
        decode_lit(8'h00, 8'h00);
        decode_lit(8'h80, 8'hFF);
        decode_lit(8'hFF, 8'hAA);

        // Backpressure, with input noise while decoding.
        @(negedge clk);
        #1;
        out_ready = 1'b0;
        g_in      = 8'h5A;
        in_valid  = 1'b1;
        exp_q.push_back(8'h6C);
        lit_req++;
        wait_accept(ok);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            #1;
            if (out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            in_valid = 1'($urandom_range(0, 1));
            g_in     = W'($urandom);
        end
        if (!ok) to_req++;
        in_valid = 1'b0;
        repeat (20) @(negedge clk);
        #1 out_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Reset three cycles into a word.
        #1;
        g_in     = 8'h3C;
        in_valid = 1'b1;
        wait_accept(ok);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        decode_lit(8'b10101010, 8'b11001100);

        // Random traffic against the model.
        repeat (300) begin
            @(negedge clk);
            #1;
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            g_in      = W'($urandom);
        end
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (W + 4) @(negedge clk);

        // Loopback sweep: encoder output of every binary value, back-to-back.
        #1;
        sweep_base = acc_cnt;
        sweep      = 1'b1;
        in_valid   = 1'b1;
        for (int v = 0; v < (1 << W); v++) begin
            vb   = W'(v);
            g_in = vb ^ (vb >> 1);
            wait_accept(ok);
            if (!ok) break;
        end
        in_valid = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            #2;
            if (lb_next == (1 << W)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) to_req++;
        sweep = 1'b0;

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/part3_gray_decoder.md
# part3_gray_decoder

Sequential Gray-to-binary decoder, the receive-side counterpart of the combinational `part3` binary-to-Gray encoder (`y = x ^ (x >> 1)`). It accepts one Gray-coded word per valid/ready transaction and reconstructs the binary value MSB-first, one bit per clock. It returns the result on a valid/ready output port. Encoder output feeds this block directly, so `part3` followed by `part3_gray_decoder` is an identity path.

## Interface
- `WIDTH`, default 8, word width in bits; must be ≥ 2.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  `g_in` holds a word to decode.
- `in_ready`  output  1  block can accept a word; high only in IDLE.
- `g_in`  input  WIDTH  Gray-coded word.
- `out_valid`  output  1  `y_out` holds a decoded word.
- `out_ready`  input  1  consumer accepts `y_out`.
- `y_out`  output  WIDTH  decoded binary word.
- `busy`  output  1  high in DECODE or DONE.

## Operation
- The FSM has three states: IDLE, DECODE and DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid && in_ready`:
    - Latch `g_in` into `g_reg`.
    - Set `idx`=WIDTH-1 and clear `y_reg`.
    - Go to DECODE.
  - `g_in` is sampled only at the accept edge. Later changes to it are ignored.
- **DECODE**
  - Each cycle writes exactly one bit of `y_reg`:
    - At `idx`=WIDTH-1: `y_reg[idx] = g_reg[idx]`.
    - Otherwise: `y_reg[idx] = y_reg[idx+1] ^ g_reg[idx]`.
  - `idx` decrements after each bit.
  - After the cycle that writes bit 0, go to DONE.
  - The `idx` counter width is `$clog2(WIDTH)`. It does not wrap: the transition to DONE happens in place of decrementing below 0.
- **DONE**
  - `out_valid`=1 and `y_out`=`y_reg`, both held stable until the handshake.
  - On `out_valid && out_ready`, go to IDLE.
  - If `out_ready` stays low, DONE holds indefinitely with no data loss.
- **Output behaviour by state**
  - `y_out` is driven from `y_reg` in every state.
  - Its value is architecturally meaningful only while `out_valid`=1.
- **Flow control and arithmetic**
  - No pipelining: at most one word in flight.
  - `in_valid` asserted in DECODE or DONE is ignored; the producer must hold it.
  - Arithmetic is pure XOR with no carries or width growth.
- **Reset**
  - Values: state=IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `y_out`=0, `idx`=0, `g_reg`=0.
  - Reset asserted mid-DECODE or in DONE aborts the word immediately, asynchronously and without completion.
  - After reset deasserts, the first rising edge may accept a new word.

## Timing
- An accept at rising edge k means `busy`=1 and `in_ready`=0 from edge k.
- DECODE occupies edges k+1 … k+WIDTH.
- `out_valid` rises at edge k+WIDTH.
- If `out_ready`=1 continuously:
  - The output handshake completes at edge k+WIDTH+1.
  - `in_ready` returns high at edge k+WIDTH+1.
  - The next accept is possible at edge k+WIDTH+2.
  - Throughput is one word per WIDTH+2 cycles.
- A handshake in DONE and a new `in_valid` in the same cycle do not overlap: the new word is accepted no earlier than the following edge.
- All outputs are registered or decoded from the state register. There is no combinational path from any input to any output.

## Structure
- Shared package `part3_pkg` holds:
  - State encoding constants `ST_IDLE`=2'd0, `ST_DECODE`=2'd1, `ST_DONE`=2'd2.
  - `GRAY_W`=8, used as the default `WIDTH` for both `part3` and this block.
- There are no sub-modules. FSM, index counter and datapath form one module.
- A loopback bench wrapper `part3_loopback` (`part3` → `part3_gray_decoder`) is permitted as a verification-only top level.

## Test plan
- **Decode A:** reset, then accept `g_in`=8'b10101010 with `out_ready`=1 → `out_valid` is asserted 8 edges after the accept, with `y_out`=8'b11001100.
- **Decode B:** accept `g_in`=8'b11001100 → `y_out`=8'b10001000.
- **Corner values:** 8'h00 → 8'h00; 8'h80 → 8'hFF; 8'hFF → 8'hAA.
- **Backpressure:**
  - Hold `out_ready`=0 for 20 cycles after `out_valid` rises → `y_out` and `out_valid` stay stable and `in_ready` stays 0.
  - Toggle `g_in` and `in_valid` during DECODE → the result is unaffected.
- **Mid-operation reset:** assert `rst` 3 cycles after an accept → all outputs return to their reset values immediately. After release, accepting 8'b10101010 yields 8'b11001100.
- **Loopback sweep:** drive all 256 binary values through `part3` into the decoder back-to-back → each `y_out` equals the original value, with one result per 10 cycles.
